// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a registered 8-bit ALU.
// The winning port's opcode and operands are captured, then executed in the next cycle.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] res,
  output logic       ovf,
  output logic       br,
  output logic       busy
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state, state_d;
  logic       last;       // port served most recently; 1 after reset so port 0 wins the first tie
  logic       cap_port;
  logic [2:0] cap_op;
  logic [7:0] cap_a, cap_b;
  logic       take, win1;
  logic [7:0] sum, diff, alu_res;
  logic       alu_ovf, alu_br;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state;
    take    = 1'b0;
    win1    = req1 & (~req0 | ~last);
    case (state)
      IDLE: if (req0 | req1) begin
        take    = 1'b1;
        state_d = EXEC;
      end
      EXEC: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sum     = cap_a + cap_b;
    diff    = cap_a - cap_b;
    alu_res = 8'h00;
    alu_ovf = 1'b0;
    alu_br  = 1'b0;
    case (cap_op)
      3'b000: begin
        alu_res = sum;
        alu_ovf = (cap_a[7] == cap_b[7]) && (sum[7] != cap_a[7]);
      end
      3'b001: begin
        alu_res = diff;
        alu_ovf = (cap_a[7] != cap_b[7]) && (diff[7] != cap_a[7]);
      end
      3'b010: begin
        alu_res = cap_a - 8'd1;
        alu_ovf = (cap_a == 8'h80);
      end
      3'b011: begin
        alu_res = cap_a + 8'd1;
        alu_ovf = (cap_a == 8'h7F);
      end
      3'b100: alu_res = cap_a & cap_b;
      3'b101: alu_res = cap_a | cap_b;
      3'b110: alu_br  = (cap_a == cap_b);
      3'b111: alu_br  = (cap_a > cap_b);
      default: alu_res = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      res      <= 8'h00;
      ovf      <= 1'b0;
      br       <= 1'b0;
      last     <= 1'b1;
      cap_port <= 1'b0;
    end else begin
      state <= state_d;
      gnt0  <= take & ~win1;
      gnt1  <= take & win1;
      done0 <= (state == EXEC) & ~cap_port;
      done1 <= (state == EXEC) & cap_port;
      if (take) begin
        last     <= win1;
        cap_port <= win1;
      end
      if (state == EXEC) begin
        res <= alu_res;
        ovf <= alu_ovf;
        br  <= alu_br;
      end
    end
  end

  // NOTE: operand capture registers carry no reset; they are always loaded on the grant edge before use.
  always_ff @(posedge clk) begin
    if (take) begin
      cap_op <= win1 ? op1 : op0;
      cap_a  <= win1 ? a1  : a0;
      cap_b  <= win1 ? b1  : b0;
    end
  end

  assign busy = (state == EXEC);

endmodule
